// File: rtl/bus_arbiter_rr_if.sv
// Bus-arbitration signal bundle: requests in, grants/enables/status out.
interface bus_arbiter_rr_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] oe_n;
  logic             busy;
  logic [OW-1:0]    owner;

  // Arbiter side
  modport master (input req, output gnt, oe_n, busy, owner);
  // Requester / bus-driver side
  modport slave (output req, input gnt, oe_n, busy, owner);
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for a shared tristated data bus with a dead
// turnaround cycle between owners and optional hold-time preemption.
module bus_arbiter_rr #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  bus_arbiter_rr_if.master    bus
);
  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     last_q, last_d;
  logic [HW-1:0]     hold_q, hold_d;

  logic              any_req;
  logic [OW-1:0]     win;
  logic              others;
  logic              hold_full;

  // Winner search: first requester after the last grantee, wrapping around
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      int unsigned idx;
      idx = (32'(last_q) + i) % N_REQ;
      if (!any_req && bus.req[OW'(idx)]) begin
        any_req = 1'b1;
        win     = OW'(idx);
      end
    end
  end

  // Preemption qualifiers: someone else waiting, and owner at its hold limit
  always_comb begin
    others    = |(bus.req & ~gnt_q);
    hold_full = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE, TURN: begin
        gnt_d = '0;
        if (any_req) begin
          state_d    = GRANT;
          gnt_d[win] = 1'b1;
          owner_d    = win;
          last_d     = win;
          hold_d     = HW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[owner_q] || (hold_full && others)) begin
          state_d = TURN;
          gnt_d   = '0;
        end else if ((MAX_HOLD != 0) && !hold_full) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; oe_n/busy are derived from the next grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      last_q    <= OW'(N_REQ - 1);
      hold_q    <= '0;
      bus.gnt   <= '0;
      bus.oe_n  <= '1;
      bus.busy  <= 1'b0;
      bus.owner <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      bus.gnt   <= gnt_d;
      bus.oe_n  <= ~gnt_d;
      bus.busy  <= |gnt_d;
      bus.owner <= owner_d;
    end
  end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: one instance with MAX_HOLD=8,
// one with unlimited hold; expectations queued on drive, checked after the edge.
module tb_bus_arbiter_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] owner;
  } exp_t;

  exp_t sb[$];
  exp_t exp_v;

  bus_arbiter_rr_if #(.N_REQ(4)) if8 ();
  bus_arbiter_rr_if #(.N_REQ(4)) if0 ();

  bus_arbiter_rr #(.N_REQ(4), .MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  bus_arbiter_rr #(.N_REQ(4), .MAX_HOLD(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

  always #5 clk = ~clk;

  // Cycle-level invariants on both instances
  logic [3:0] prev8 = '0;
  logic [3:0] prev0 = '0;
  always @(negedge clk) begin
    checks = checks + 2;
    if (!$onehot0(if8.gnt) || if8.oe_n !== ~if8.gnt || if8.busy !== (|if8.gnt) ||
        (prev8 != 0 && if8.gnt != 0 && prev8 != if8.gnt)) begin
      errors++;
      $display("FAIL invariant8 t=%0t: gnt=%b oe_n=%b busy=%b prev_gnt=%b required one-hot gnt, oe_n=~gnt, busy=|gnt, gap between owners",
               $time, if8.gnt, if8.oe_n, if8.busy, prev8);
    end
    if (!$onehot0(if0.gnt) || if0.oe_n !== ~if0.gnt || if0.busy !== (|if0.gnt) ||
        (prev0 != 0 && if0.gnt != 0 && prev0 != if0.gnt)) begin
      errors++;
      $display("FAIL invariant0 t=%0t: gnt=%b oe_n=%b busy=%b prev_gnt=%b required one-hot gnt, oe_n=~gnt, busy=|gnt, gap between owners",
               $time, if0.gnt, if0.oe_n, if0.busy, prev0);
    end
    prev8 <= if8.gnt;
    prev0 <= if0.gnt;
  end

  task automatic test_reset();
    if8.req = '0;
    if0.req = '0;
    rst = 1'b1;
    sb.push_back('{gnt: 4'b0000, owner: 2'd0});
    #12;
    exp_v = sb.pop_front();
    checks++;
    if (if8.gnt !== exp_v.gnt || if8.oe_n !== ~exp_v.gnt || if8.busy !== 1'b0 || if8.owner !== exp_v.owner) begin
      errors++;
      $display("FAIL reset8: gnt=%b oe_n=%b busy=%b owner=%0d required gnt=%b oe_n=%b busy=0 owner=%0d",
               if8.gnt, if8.oe_n, if8.busy, if8.owner, exp_v.gnt, ~exp_v.gnt, exp_v.owner);
    end
    checks++;
    if (if0.gnt !== exp_v.gnt || if0.oe_n !== ~exp_v.gnt || if0.busy !== 1'b0 || if0.owner !== exp_v.owner) begin
      errors++;
      $display("FAIL reset0: gnt=%b oe_n=%b busy=%b owner=%0d required gnt=%b oe_n=%b busy=0 owner=%0d",
               if0.gnt, if0.oe_n, if0.busy, if0.owner, exp_v.gnt, ~exp_v.gnt, exp_v.owner);
    end
    #8 rst = 1'b0;
  endtask

  // Single request: 1-edge grant latency, release through TURN into IDLE
  task automatic test_single();
    logic [3:0] rq [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] eg [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    for (int n = 0; n < 4; n++) begin
      if8.req = rq[n];
      sb.push_back('{gnt: eg[n], owner: 2'd0});
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (if8.gnt !== exp_v.gnt || if8.oe_n !== ~exp_v.gnt || if8.busy !== (|exp_v.gnt) || if8.owner !== exp_v.owner) begin
        errors++;
        $display("FAIL single cyc%0d: gnt=%b oe_n=%b busy=%b owner=%0d required gnt=%b oe_n=%b busy=%b owner=%0d",
                 n, if8.gnt, if8.oe_n, if8.busy, if8.owner, exp_v.gnt, ~exp_v.gnt, |exp_v.gnt, exp_v.owner);
      end
    end
  endtask

  // All four requesting: 8-cycle holds, one TURN, rotation 0,1,2,3,0
  task automatic test_rotate();
    #2 rst = 1'b1;
    #4 rst = 1'b0;
    for (int n = 0; n < 46; n++) begin
      int o;
      logic [3:0] g;
      o = (n < 45) ? (n / 9) % 4 : 0;
      g = 4'(1) << o;
      if (n >= 45 || (n % 9) == 8) g = 4'b0000;
      if8.req = (n < 45) ? 4'b1111 : 4'b0000;
      sb.push_back('{gnt: g, owner: 2'(o)});
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (if8.gnt !== exp_v.gnt || if8.oe_n !== ~exp_v.gnt || if8.busy !== (|exp_v.gnt) || if8.owner !== exp_v.owner) begin
        errors++;
        $display("FAIL rotate cyc%0d: gnt=%b oe_n=%b busy=%b owner=%0d required gnt=%b oe_n=%b busy=%b owner=%0d",
                 n, if8.gnt, if8.oe_n, if8.busy, if8.owner, exp_v.gnt, ~exp_v.gnt, |exp_v.gnt, exp_v.owner);
      end
    end
  endtask

  // Lone requester is never preempted; hold count saturates so a late
  // competitor preempts at once
  task automatic test_solo();
    for (int n = 0; n < 24; n++) begin
      logic [3:0] g;
      logic [1:0] o;
      if (n < 20)       begin if8.req = 4'b0100; g = 4'b0100; o = 2'd2; end
      else if (n == 20) begin if8.req = 4'b0101; g = 4'b0000; o = 2'd2; end
      else if (n == 21) begin if8.req = 4'b0101; g = 4'b0001; o = 2'd0; end
      else              begin if8.req = 4'b0000; g = 4'b0000; o = 2'd0; end
      sb.push_back('{gnt: g, owner: o});
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (if8.gnt !== exp_v.gnt || if8.oe_n !== ~exp_v.gnt || if8.busy !== (|exp_v.gnt) || if8.owner !== exp_v.owner) begin
        errors++;
        $display("FAIL solo cyc%0d: gnt=%b oe_n=%b busy=%b owner=%0d required gnt=%b oe_n=%b busy=%b owner=%0d",
                 n, if8.gnt, if8.oe_n, if8.busy, if8.owner, exp_v.gnt, ~exp_v.gnt, |exp_v.gnt, exp_v.owner);
      end
    end
  endtask

  // Owner 3 releases with 0 and 1 waiting: TURN, wrap to 0, later 1
  task automatic test_wrap();
    logic [3:0] rq [8] = '{4'b1000, 4'b1011, 4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    logic [3:0] eg [8] = '{4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    logic [1:0] eo [8] = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    for (int n = 0; n < 8; n++) begin
      if8.req = rq[n];
      sb.push_back('{gnt: eg[n], owner: eo[n]});
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (if8.gnt !== exp_v.gnt || if8.oe_n !== ~exp_v.gnt || if8.busy !== (|exp_v.gnt) || if8.owner !== exp_v.owner) begin
        errors++;
        $display("FAIL wrap cyc%0d: gnt=%b oe_n=%b busy=%b owner=%0d required gnt=%b oe_n=%b busy=%b owner=%0d",
                 n, if8.gnt, if8.oe_n, if8.busy, if8.owner, exp_v.gnt, ~exp_v.gnt, |exp_v.gnt, exp_v.owner);
      end
    end
  endtask

  // Asynchronous reset in the middle of a grant, then pointer back at 0
  task automatic test_reset_mid();
    for (int n = 0; n < 5; n++) begin
      logic [3:0] g;
      logic [1:0] o;
      case (n)
        0: begin if8.req = 4'b0010; g = 4'b0010; o = 2'd1; end
        1: begin g = 4'b0000; o = 2'd0; end
        2: begin if8.req = 4'b0110; g = 4'b0010; o = 2'd1; end
        default: begin if8.req = 4'b0000; g = 4'b0000; o = 2'd1; end
      endcase
      sb.push_back('{gnt: g, owner: o});
      if (n == 1) begin
        #2 rst = 1'b1;
        #1;
      end else begin
        @(posedge clk); #1;
      end
      exp_v = sb.pop_front();
      checks++;
      if (if8.gnt !== exp_v.gnt || if8.oe_n !== ~exp_v.gnt || if8.busy !== (|exp_v.gnt) || if8.owner !== exp_v.owner) begin
        errors++;
        $display("FAIL reset_mid step%0d: gnt=%b oe_n=%b busy=%b owner=%0d required gnt=%b oe_n=%b busy=%b owner=%0d",
                 n, if8.gnt, if8.oe_n, if8.busy, if8.owner, exp_v.gnt, ~exp_v.gnt, |exp_v.gnt, exp_v.owner);
      end
      if (n == 1) begin
        #2 rst = 1'b0;
      end
    end
  endtask

  // Unlimited hold: owner 0 keeps the bus until it drops its request
  task automatic test_unlimited();
    for (int n = 0; n < 16; n++) begin
      logic [3:0] g;
      logic [1:0] o;
      if (n < 12)       begin if0.req = 4'b0011; g = 4'b0001; o = 2'd0; end
      else if (n == 12) begin if0.req = 4'b0010; g = 4'b0000; o = 2'd0; end
      else if (n == 13) begin if0.req = 4'b0010; g = 4'b0010; o = 2'd1; end
      else              begin if0.req = 4'b0000; g = 4'b0000; o = 2'd1; end
      sb.push_back('{gnt: g, owner: o});
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      checks++;
      if (if0.gnt !== exp_v.gnt || if0.oe_n !== ~exp_v.gnt || if0.busy !== (|exp_v.gnt) || if0.owner !== exp_v.owner) begin
        errors++;
        $display("FAIL unlimited cyc%0d: gnt=%b oe_n=%b busy=%b owner=%0d required gnt=%b oe_n=%b busy=%b owner=%0d",
                 n, if0.gnt, if0.oe_n, if0.busy, if0.owner, exp_v.gnt, ~exp_v.gnt, |exp_v.gnt, exp_v.owner);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_solo();
    test_wrap();
    test_reset_mid();
    test_unlimited();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
